adder_result_buffer: RTL and testbench

Downstream stage for the N-bit ripple adder. Captures each `{carry_out, sum}` result the adder produces into a small synchronous FIFO. Tags every entry with zero and parity flags, and presents the entries in order to the consumer through a valid/ready handshake. It decouples the purely combinational adder from a consumer that may stall.

---
 rtl/adder_result_buffer_pkg.sv | 29 ++
 rtl/adder_result_buffer_fifo_mem.sv | 26 ++
 rtl/adder_result_buffer.sv | 128 ++++++++++++
 tb/tb_adder_result_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_result_buffer_pkg.sv
// Shared types and helpers for the adder result buffer: entry layout, stats width,
// and the zero/parity flag function applied to {carry, sum} at push time.
package adder_result_buffer_pkg;

  localparam int unsigned RESULT_SUM_W  = 2;
  localparam int unsigned STATS_W       = 16;
  localparam int unsigned FLAG_IN_MAX_W = 64;

  typedef struct packed {
    logic                    zero;
    logic                    parity;
    logic                    carry;
    logic [RESULT_SUM_W-1:0] sum;
  } result_entry_t;

  typedef struct packed {
    logic zero;
    logic parity;
  } result_flags_t;

  // Callers zero-extend {carry, sum}; extra zero bits change neither flag.
  function automatic result_flags_t calc_flags(input logic [FLAG_IN_MAX_W-1:0] bits);
    result_flags_t f;
    f.zero   = ~|bits;
    f.parity = ^bits;
    return f;
  endfunction

endpackage

// File: rtl/adder_result_buffer_fifo_mem.sv
// Register-array storage for the result FIFO: one synchronous write port and
// one asynchronous read port. Contents are not reset.
module result_fifo_mem #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 5,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/adder_result_buffer.sv
// Buffers {carry_out, sum} results of the ripple adder in a small FIFO with stored
// zero/parity flags and a valid/ready output. ADDER_RESULT_STATS_EN adds push counters.
module adder_result_buffer
  import adder_result_buffer_pkg::*;
#(
  parameter  int unsigned N     = 2,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_parity,
  output logic [LVL_W-1:0] level
`ifdef ADDER_RESULT_STATS_EN
  ,
  output logic [STATS_W-1:0] result_count,
  output logic [STATS_W-1:0] carry_count
`endif
);

  localparam int unsigned ENTRY_W = N + 3;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               push, pop;
  result_flags_t      in_flags;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // Handshake depends on state only; rst forces in_ready low so nothing is taken during reset.
  assign in_ready  = !rst && (level_q != FULL_LEVEL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign in_flags = calc_flags(FLAG_IN_MAX_W'({in_carry, in_sum}));
  assign wr_entry = {in_flags.zero, in_flags.parity, in_carry, in_sum};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  result_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry)
  );

  // Storage is never cleared, so outputs are masked to zero while empty.
  assign out_sum    = out_valid ? rd_entry[N-1:0] : '0;
  assign out_carry  = out_valid & rd_entry[N];
  assign out_parity = out_valid & rd_entry[N+1];
  assign out_zero   = out_valid & rd_entry[N+2];
  assign level      = level_q;

`ifdef ADDER_RESULT_STATS_EN
  logic [STATS_W-1:0] result_count_q, result_count_d;
  logic [STATS_W-1:0] carry_count_q, carry_count_d;

  always_comb begin
    result_count_d = result_count_q;
    carry_count_d  = carry_count_q;
    if (push) begin
      result_count_d = result_count_q + 1'b1;
      if (in_carry) begin
        carry_count_d = carry_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_count_q <= '0;
      carry_count_q  <= '0;
    end else begin
      result_count_q <= result_count_d;
      carry_count_q  <= carry_count_d;
    end
  end

  assign result_count = result_count_q;
  assign carry_count  = carry_count_q;
`endif

endmodule

// File: tb/tb_adder_result_buffer.sv
// Self-checking bench for adder_result_buffer (N=2, DEPTH=4): vector table plus
// hand-written fill/backpressure, wrap-stress scoreboard and mid-operation reset sequences.
module tb_adder_result_buffer;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_carry;
  logic [1:0] in_sum;
  logic       out_valid, out_ready, out_carry, out_zero, out_parity;
  logic [1:0] out_sum;
  logic [2:0] level;
`ifdef ADDER_RESULT_STATS_EN
  logic [15:0] result_count, carry_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_result_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .level      (level)
`ifdef ADDER_RESULT_STATS_EN
    ,
    .result_count (result_count),
    .carry_count  (carry_count)
`endif
  );

  typedef struct {
    logic       in_valid;
    logic [1:0] in_sum;
    logic       in_carry;
    logic       out_ready;
    int         exp_level;
    logic       exp_valid;
    logic [1:0] exp_sum;
    logic       exp_carry;
    logic       exp_zero;
    logic       exp_parity;
  } vector_t;

  vector_t vecs[8];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic c, input logic r);
    in_valid  = v;
    in_sum    = s;
    in_carry  = c;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic v, input logic [1:0] s,
                           input logic c, input logic z, input logic p);
    checkOutput({tag, " out_valid"}, out_valid, v);
    checkOutput({tag, " out_sum"}, out_sum, s);
    checkOutput({tag, " out_carry"}, out_carry, c);
    checkOutput({tag, " out_zero"}, out_zero, z);
    checkOutput({tag, " out_parity"}, out_parity, p);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drain_exp[4];
    int sb[$];
    int mlevel;
    int pushed;
    int entry;
    logic p, q;

    // Expected values are the state after the clock edge that applies each vector.
    vecs[0] = '{1'b1, 2'd3, 1'b1, 1'b0, 1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 2'd0, 1'b0, 1'b0, 2, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 2'd0, 1'b0, 1'b1, 1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 1'b0, 1'b1, 0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 2'd1, 1'b0, 1'b0, 1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 2'd2, 1'b1, 1'b1, 1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 2'd3, 1'b0, 1'b1, 1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 2'd0, 1'b0, 1'b1, 0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

    // Reset and idle
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset level", level, 0);
    checkHead("reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("release in_ready", in_ready, 1);
    tick();
    checkOutput("idle in_ready", in_ready, 1);
    checkOutput("idle level", level, 0);
    checkHead("idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Table-driven push/pop vectors
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].in_valid, vecs[i].in_sum, vecs[i].in_carry, vecs[i].out_ready);
      tick();
      checkOutput($sformatf("vec%0d level", i), level, vecs[i].exp_level);
      checkOutput($sformatf("vec%0d in_ready", i), in_ready, 1);
      checkHead($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_sum,
                vecs[i].exp_carry, vecs[i].exp_zero, vecs[i].exp_parity);
    end

    // Fill to full, hold a fifth offer, then drain
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 2'(k), 1'b0, 1'b0);
      tick();
    end
    checkOutput("full level", level, 4);
    checkOutput("full in_ready", in_ready, 0);
    checkOutput("full head", out_sum, 0);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    checkOutput("held level", level, 4);
    checkOutput("held in_ready", in_ready, 0);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
    #1;
    checkOutput("full pop head", out_sum, 0);
    tick();
    checkOutput("full pop level", level, 3);
    checkOutput("full pop in_ready", in_ready, 1);
    checkOutput("full pop next head", out_sum, 1);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    checkOutput("refill level", level, 4);
    drain_exp = '{1, 2, 3, 1};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      #1;
      checkOutput($sformatf("drain%0d valid", i), out_valid, 1);
      checkOutput($sformatf("drain%0d sum", i), out_sum, drain_exp[i]);
      tick();
    end
    checkOutput("drained level", level, 0);
    checkOutput("drained valid", out_valid, 0);

    // Wrap stress against a queue scoreboard
    mlevel = 0;
    pushed = 0;
    for (int cyc = 0; cyc < 300 && (pushed < 20 || mlevel != 0); cyc++) begin
      applyStimulus(pushed < 20, 2'(pushed % 4), 1'((pushed / 4) % 2), 1'($urandom_range(0, 1)));
      #1;
      p = in_valid && (mlevel != DEPTH);
      q = out_ready && (mlevel != 0);
      checkOutput("stress in_ready", in_ready, int'(mlevel != DEPTH));
      checkOutput("stress out_valid", out_valid, int'(mlevel != 0));
      if (q) begin
        entry = sb.pop_front();
        checkOutput("stress out_sum", out_sum, entry % 4);
        checkOutput("stress out_carry", out_carry, entry / 4);
      end
      if (p) begin
        sb.push_back(int'(in_carry) * 4 + int'(in_sum));
        pushed++;
      end
      tick();
      mlevel = mlevel + int'(p) - int'(q);
      checkOutput("stress level", level, mlevel);
    end
    checkOutput("stress pushed", pushed, 20);
    checkOutput("stress remaining", mlevel, 0);

    // Reset during a simultaneous push and pop
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 2'(k), 1'b1, 1'b0);
      tick();
    end
    checkOutput("prereset level", level, 3);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midreset in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    #1;
    checkOutput("postreset level", level, 0);
    checkOutput("postreset in_ready", in_ready, 1);
    checkHead("postreset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
`ifdef ADDER_RESULT_STATS_EN
    checkOutput("postreset result_count", result_count, 0);
    checkOutput("postreset carry_count", carry_count, 0);
`endif
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 2'(k % 4), (k == 0) || (k == 3), 1'b1);
      #1;
      checkOutput($sformatf("count push%0d in_ready", k), in_ready, 1);
      tick();
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("count level", level, 0);
`ifdef ADDER_RESULT_STATS_EN
    checkOutput("result_count", result_count, 5);
    checkOutput("carry_count", carry_count, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
